// File: rtl/gpp_pkg.sv
// Shared opcode, register-select and FSM state encodings for the register
// transfer controller, plus the command validity rule.
package gpp_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_MOVE = 2'b01,
      OP_READ = 2'b10,
      OP_SWAP = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SEL_X   = 2'b00,
      SEL_Y   = 2'b01,
      SEL_ACC = 2'b10,
      SEL_INV = 2'b11
   } sel_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_B = 3'd4,
      ST_RESP = 3'd5
   } state_e;

   // LOAD never looks at src and READ never looks at dst, so those may hold 11.
   function automatic logic cmd_invalid(op_e op, logic [1:0] src, logic [1:0] dst);
      logic uses_src;
      logic uses_dst;
      uses_src = (op != OP_LOAD);
      uses_dst = (op != OP_READ);
      return (uses_src && (src == SEL_INV)) || (uses_dst && (dst == SEL_INV));
   endfunction

endpackage

// File: rtl/reg_transfer_controller_if.sv
// Command, response and register-file bus of the register transfer controller.
// The controller takes the slave side; the environment takes the master side.
interface reg_transfer_controller_if;
   import gpp_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [1:0]        cmd_src;
   logic [1:0]        cmd_dst;
   logic [DATA_W-1:0] cmd_imm;

   logic [DATA_W-1:0] rf_data_in;
   logic              rf_write_x;
   logic              rf_write_y;
   logic              rf_write_acc;
   logic              rf_read_x;
   logic              rf_read_y;
   logic              rf_read_acc;
   logic [DATA_W-1:0] rf_data_out;
   logic [DATA_W-1:0] rf_data_out_acc;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      input  rf_data_out, rf_data_out_acc, rsp_ready,
      output cmd_ready, rf_data_in,
      output rf_write_x, rf_write_y, rf_write_acc,
      output rf_read_x, rf_read_y, rf_read_acc,
      output rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      output rf_data_out, rf_data_out_acc, rsp_ready,
      input  cmd_ready, rf_data_in,
      input  rf_write_x, rf_write_y, rf_write_acc,
      input  rf_read_x, rf_read_y, rf_read_acc,
      input  rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/reg_sel_decoder.sv
// Maps a 2-bit register select plus enable onto a one-hot {ACC, Y, X} strobe
// triple; select 11 never produces a strobe.
module reg_sel_decoder (
   input  logic       en,
   input  logic [1:0] sel,
   output logic [2:0] hot
);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_hot
         assign hot[gi] = en && (sel == 2'(gi));
      end
   endgenerate

endmodule

// File: rtl/reg_transfer_controller.sv
// Sequences LOAD/MOVE/READ/SWAP register transfers over a register-file bus
// and returns one response per accepted command.
module reg_transfer_controller
   import gpp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   reg_transfer_controller_if.slave bus
);

   state_e            state_reg;
   state_e            state_next;
   op_e               op_reg;
   logic [1:0]        src_reg;
   logic [1:0]        dst_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [DATA_W-1:0] tmp_a_reg;
   logic [DATA_W-1:0] tmp_b_reg;
   logic              err_reg;

   logic              accept;
   logic              cmd_bad;
   logic              rd_en;
   logic              wr_en;
   logic [1:0]        rd_sel;
   logic [1:0]        wr_sel;
   logic [2:0]        rd_hot;
   logic [2:0]        wr_hot;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] wr_data;

   assign accept  = (state_reg == ST_IDLE) && bus.cmd_valid;
   assign cmd_bad = cmd_invalid(op_e'(bus.cmd_op), bus.cmd_src, bus.cmd_dst);
   assign rd_data = rd_hot[2] ? bus.rf_data_out_acc : bus.rf_data_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         op_reg    <= OP_LOAD;
         src_reg   <= '0;
         dst_reg   <= '0;
         imm_reg   <= '0;
         tmp_a_reg <= '0;
         tmp_b_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg  <= op_e'(bus.cmd_op);
            src_reg <= bus.cmd_src;
            dst_reg <= bus.cmd_dst;
            imm_reg <= bus.cmd_imm;
            err_reg <= cmd_bad;
         end
         // Read data is combinational, so it is captured in the enable cycle.
         if (state_reg == ST_RD_A) tmp_a_reg <= rd_data;
         if (state_reg == ST_RD_B) tmp_b_reg <= rd_data;
      end
   end

   always_comb begin
      state_next = state_reg;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      rd_sel     = src_reg;
      wr_sel     = dst_reg;
      wr_data    = '0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               if (cmd_bad)                              state_next = ST_RESP;
               else if (op_e'(bus.cmd_op) == OP_LOAD)    state_next = ST_WR_A;
               else                                      state_next = ST_RD_A;
            end
         end
         ST_RD_A: begin
            rd_en  = 1'b1;
            rd_sel = src_reg;
            if (op_reg == OP_SWAP)      state_next = ST_RD_B;
            else if (op_reg == OP_MOVE) state_next = ST_WR_A;
            else                        state_next = ST_RESP;
         end
         ST_RD_B: begin
            rd_en      = 1'b1;
            rd_sel     = dst_reg;
            state_next = ST_WR_A;
         end
         ST_WR_A: begin
            wr_en      = 1'b1;
            wr_sel     = dst_reg;
            wr_data    = (op_reg == OP_LOAD) ? imm_reg : tmp_a_reg;
            state_next = (op_reg == OP_SWAP) ? ST_WR_B : ST_RESP;
         end
         ST_WR_B: begin
            wr_en      = 1'b1;
            wr_sel     = src_reg;
            wr_data    = tmp_b_reg;
            state_next = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   reg_sel_decoder u_rd_dec (
      .en  (rd_en),
      .sel (rd_sel),
      .hot (rd_hot)
   );

   reg_sel_decoder u_wr_dec (
      .en  (wr_en),
      .sel (wr_sel),
      .hot (wr_hot)
   );

   assign bus.cmd_ready    = (state_reg == ST_IDLE);
   assign bus.rf_read_x    = rd_hot[0];
   assign bus.rf_read_y    = rd_hot[1];
   assign bus.rf_read_acc  = rd_hot[2];
   assign bus.rf_write_x   = wr_hot[0];
   assign bus.rf_write_y   = wr_hot[1];
   assign bus.rf_write_acc = wr_hot[2];
   assign bus.rf_data_in   = wr_data;

   // Response fields are built purely from latched state, so they hold until the handshake.
   assign bus.rsp_valid = (state_reg == ST_RESP);
   assign bus.rsp_err   = bus.rsp_valid && err_reg;
   assign bus.rsp_data  = (bus.rsp_valid && !err_reg && (op_reg == OP_READ)) ? tmp_a_reg : '0;

endmodule

// File: doc/reg_transfer_controller.md
REG_TRANSFER_CONTROLLER -- requirements
Module: reg_transfer_controller

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-low, and clock clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at rising edge
- cmd_op  in  2  00 LOAD, 01 MOVE, 10 READ, 11 SWAP
- cmd_src  in  2  source register select: 00 X, 01 Y, 10 ACC, 11 invalid
- cmd_dst  in  2  destination register select, same coding
- cmd_imm  in  16  immediate for LOAD
- rf_data_in  out  16  write data to register file
- rf_write_x / rf_write_y / rf_write_acc  out  1 each  write strobes
- rf_read_x / rf_read_y / rf_read_acc  out  1 each  read enables
- rf_data_out  in  16  combinational X/Y read data
- rf_data_out_acc  in  16  combinational ACC read data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready at rising edge
- rsp_data  out  16  READ value, else 0
- rsp_err  out  1  invalid select in command

Function
REQ-003 FSM states SHALL be IDLE, RD_A, RD_B, WR_A, WR_B, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On acceptance, op/src/dst/imm SHALL be latched; later input changes SHALL have no effect until return to IDLE.
REQ-005 At most one rf_write_* and at most one rf_read_* SHALL be high in any cycle; all strobes SHALL be 0 in IDLE and RESP.
REQ-006 Read data SHALL be captured in the same cycle as the read enable: rf_data_out for X/Y, rf_data_out_acc for ACC.
REQ-007 LOAD (accepted edge T) SHALL run WR_A at T+1, driving rf_data_in=imm and the dst strobe; rsp_valid SHALL be 1 from T+2.
REQ-008 MOVE SHALL run RD_A at T+1 (read src into tmp_a), then WR_A at T+2 (write tmp_a to dst), then RESP at T+3.
REQ-009 READ SHALL run RD_A at T+1 (read src), then RESP at T+2 with rsp_data equal to the captured value.
REQ-010 SWAP SHALL run RD_A at T+1 (src into tmp_a), RD_B at T+2 (dst into tmp_b), WR_A at T+3 (tmp_a to dst), WR_B at T+4 (tmp_b to src), then RESP at T+5.
REQ-011 MOVE or SWAP with src==dst SHALL execute normally; the register value is unchanged.
REQ-012 Any used select equal to 11 SHALL issue no strobes and SHALL enter RESP at T+1 with rsp_err=1 and rsp_data=0; unused selects (LOAD src, READ dst) SHALL be ignored.
REQ-013 In RESP, rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_ready; the FSM SHALL return to IDLE on the handshake edge.
REQ-014 rf_data_in SHALL be 0 whenever no write strobe is high.
REQ-015 rsp_data SHALL be 0 for LOAD, MOVE and SWAP responses.

Reset
REQ-016 While rst=0, the block SHALL be in IDLE, with cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, all rf strobes 0, rf_data_in=0, and tmp_a=tmp_b=0.
REQ-017 Reset asserted mid-operation SHALL abort the operation immediately with no further strobes; partially completed SWAP writes are not undone.

Structure
REQ-018 Opcode codes, register-select codes and the FSM state encoding SHALL reside in the shared package gpp_pkg.
REQ-019 One sub-module, reg_sel_decoder, SHALL map a 2-bit select plus an enable to the one-hot X/Y/ACC strobe triple.

Verification
REQ-020 The bench SHALL connect the block to the general-purpose register file model and cover these scenarios:
- LOAD X imm=A5A5, then READ X with rsp_ready=1 -> rsp_data=A5A5, rsp_err=0 at T+2.
- LOAD Y 5A5A, MOVE Y->ACC, READ ACC -> rsp_data=5A5A; rf_read_y and rf_write_acc each high exactly one cycle.
- X=1234, Y=BEEF, SWAP X,Y, then READ X and READ Y -> BEEF and 1234; rsp_valid at T+5.
- READ with src=11 -> rsp_err=1, rsp_data=0 at T+1; no strobe asserted.
- rsp_ready held 0 for 5 cycles after READ -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
- rst=0 during SWAP WR_A cycle -> all strobes 0 immediately, cmd_ready=1 after release, rsp_valid=0.
